// File: rtl/rsp_nibble_deser_pkg.sv
// Shared types and defaults for the nibble-serial read-response deserializer.
package rsp_nibble_deser_pkg;

    localparam int NIBBLE_W_DEF  = 4;
    localparam int WORD_W_DEF    = 32;
    localparam int TAG_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    typedef enum logic {
        TAG_DATA = 1'b0,
        TAG_INST = 1'b1
    } tag_t;

    function automatic tag_t to_tag(input logic is_inst);
        return is_inst ? TAG_INST : TAG_DATA;
    endfunction

endpackage

// File: rtl/rsp_nibble_deser_tag_fifo.sv
// Outstanding-request tag FIFO: records whether each issued read was a fetch or a load.
module rsp_tag_fifo
    import rsp_nibble_deser_pkg::*;
#(
    parameter int Depth = TAG_DEPTH_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  tag_t tag_i,
    output logic full_o,
    output logic empty_o,
    output logic single_o,
    output tag_t head_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    tag_t            r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o   = (r_count == CntW'(Depth));
    assign empty_o  = (r_count == '0);
    assign single_o = (r_count == CntW'(1));
    assign head_o   = r_mem[r_rd_ptr];

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= tag_i;
    end

endmodule

// File: rtl/rsp_nibble_deser.sv
// Assembles nibble-serial read responses into words and routes each to the instruction
// or data port by its request tag. Optional RSP_DESER_ERR_CHECK_EN adds a sticky unsolicited-response flag.
module rsp_nibble_deser
    import rsp_nibble_deser_pkg::*;
#(
    parameter int NibbleW  = NIBBLE_W_DEF,
    parameter int WordW    = WORD_W_DEF,
    parameter int TagDepth = TAG_DEPTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tag_push_i,
    input  logic               tag_is_inst_i,
    output logic               tag_full_o,
    input  logic [NibbleW-1:0] nib_data_i,
    input  logic               nib_valid_i,
    output logic               nib_ready_o,
    output logic [WordW-1:0]   inst_data_o,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [WordW-1:0]   data_pdata_o,
    output logic               data_pvalid_o,
    input  logic               data_pready_i,
    output logic               err_o
);

    localparam int Beats = WordW / NibbleW;
    localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

    state_t           r_state;
    logic [CntW-1:0]  r_beat;
    logic [WordW-1:0] r_word;
    logic             r_nib_ready;
    logic             r_inst_valid;
    logic             r_data_valid;

    logic w_empty;
    logic w_full;
    logic w_single;
    tag_t w_head;
    logic w_accept;
    logic w_handshake;
    logic w_tags_remain;

    rsp_tag_fifo #(
        .Depth (TagDepth)
    ) u_tag_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (tag_push_i),
        .pop_i    (w_handshake),
        .tag_i    (to_tag(tag_is_inst_i)),
        .full_o   (w_full),
        .empty_o  (w_empty),
        .single_o (w_single),
        .head_o   (w_head)
    );

    assign w_accept    = r_nib_ready && nib_valid_i;
    assign w_handshake = (r_inst_valid && inst_ready_i) || (r_data_valid && data_pready_i);
    // Only meaningful in HOLD, where the FIFO holds at least the tag being retired.
    assign w_tags_remain = !w_single || tag_push_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_word       <= '0;
            r_nib_ready  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state     <= ST_COLLECT;
                        r_nib_ready <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_word[NibbleW*r_beat +: NibbleW] <= nib_data_i;
                        if (r_beat == LastBeat) begin
                            r_beat       <= '0;
                            r_state      <= ST_HOLD;
                            r_nib_ready  <= 1'b0;
                            r_inst_valid <= (w_head == TAG_INST);
                            r_data_valid <= (w_head == TAG_DATA);
                        end else begin
                            r_beat <= r_beat + CntW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_handshake) begin
                        r_inst_valid <= 1'b0;
                        r_data_valid <= 1'b0;
                        if (w_tags_remain) begin
                            r_state     <= ST_COLLECT;
                            r_nib_ready <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_nib_ready <= 1'b0;
                end
            endcase
        end
    end

    assign tag_full_o    = w_full;
    assign nib_ready_o   = r_nib_ready;
    assign inst_data_o   = r_word;
    assign data_pdata_o  = r_word;
    assign inst_valid_o  = r_inst_valid;
    assign data_pvalid_o = r_data_valid;

`ifdef RSP_DESER_ERR_CHECK_EN
    logic r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (nib_valid_i && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rsp_nibble_deser.sv
// Bench for rsp_nibble_deser: directed scenarios plus randomized traffic against a queue-based model.
module tb_rsp_nibble_deser;

    localparam int NIB_W     = 4;
    localparam int WORD_W    = 32;
    localparam int BEATS     = WORD_W / NIB_W;
    localparam int TAG_DEPTH = 2;
`ifdef RSP_DESER_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              tag_push_i = 1'b0;
    logic              tag_is_inst_i = 1'b0;
    logic              tag_full_o;
    logic [NIB_W-1:0]  nib_data_i = '0;
    logic              nib_valid_i = 1'b0;
    logic              nib_ready_o;
    logic [WORD_W-1:0] inst_data_o;
    logic              inst_valid_o;
    logic              inst_ready_i = 1'b0;
    logic [WORD_W-1:0] data_pdata_o;
    logic              data_pvalid_o;
    logic              data_pready_i = 1'b0;
    logic              err_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_on  = 1'b0;

    rsp_nibble_deser #(
        .NibbleW  (NIB_W),
        .WordW    (WORD_W),
        .TagDepth (TAG_DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .tag_push_i    (tag_push_i),
        .tag_is_inst_i (tag_is_inst_i),
        .tag_full_o    (tag_full_o),
        .nib_data_i    (nib_data_i),
        .nib_valid_i   (nib_valid_i),
        .nib_ready_o   (nib_ready_o),
        .inst_data_o   (inst_data_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .data_pdata_o  (data_pdata_o),
        .data_pvalid_o (data_pvalid_o),
        .data_pready_i (data_pready_i),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: tags in flight, nibbles gathered so far, and the word awaiting delivery.
    bit          tq[$];
    logic [3:0]  nibs[$];
    int          m_phase = 0;   // 0 waiting for a tag, 1 gathering nibbles, 2 word on offer
    logic [31:0] m_word = '0;
    bit          m_inst = 1'b0;
    bit          m_err = 1'b0;

    always @(negedge clk) begin
        bit hs;
        bit push_ok;
        int size_after;
        chk("full", tag_full_o, tq.size() == TAG_DEPTH);
        chk("nib_ready", nib_ready_o, m_phase == 1);
        chk("inst_valid", inst_valid_o, (m_phase == 2) && m_inst);
        chk("data_valid", data_pvalid_o, (m_phase == 2) && !m_inst);
        if (m_phase == 2) begin
            chk("inst_data", inst_data_o, m_word);
            chk("data_pdata", data_pdata_o, m_word);
        end
        chk("err", err_o, m_err);

        if (rst_i) begin
            tq.delete();
            nibs.delete();
            m_phase = 0;
            m_err   = 1'b0;
        end else begin
            hs = (m_phase == 2) && (m_inst ? inst_ready_i : data_pready_i);
            if (ERR_EN && nib_valid_i && tq.size() == 0) m_err = 1'b1;
            push_ok = tag_push_i && ((tq.size() < TAG_DEPTH) || hs);
            size_after = tq.size() - int'(hs) + int'(push_ok);
            case (m_phase)
                0: if (tq.size() != 0) m_phase = 1;
                1: begin
                    if (nib_valid_i) begin
                        nibs.push_back(nib_data_i);
                        if (nibs.size() == BEATS) begin
                            m_word = '0;
                            for (int k = 0; k < BEATS; k++)
                                m_word = m_word + (32'(nibs[k]) << (NIB_W * k));
                            m_inst = tq[0];
                            nibs.delete();
                            m_phase = 2;
                        end
                    end
                end
                default: if (hs) m_phase = (size_after != 0) ? 1 : 0;
            endcase
            if (hs) void'(tq.pop_front());
            if (push_ok) tq.push_back(tag_is_inst_i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input bit inst);
        tag_push_i    = 1'b1;
        tag_is_inst_i = inst;
        tick();
        tag_push_i    = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] n);
        nib_valid_i = 1'b1;
        nib_data_i  = n;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (nib_ready_o) begin
                tick();
                nib_valid_i = 1'b0;
                return;
            end
            tick();
        end
        chk("nib_timeout", 32'd0, 32'd1);
        nib_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 0; k < BEATS; k++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
            send_nib(w[NIB_W*k +: NIB_W]);
        end
    endtask

    initial begin
        logic [31:0] w;
        repeat (3) tick();
        chk("rst_full", tag_full_o, 0);
        chk("rst_ready", nib_ready_o, 0);
        chk("rst_ivalid", inst_valid_o, 0);
        chk("rst_dvalid", data_pvalid_o, 0);
        chk("rst_word", data_pdata_o, 0);
        chk("rst_err", err_o, 0);
        rst_i = 1'b0;
        tick();

        // Data-load word, nibbles back to back, LSB first.
        push_tag(1'b0);
        for (int k = 8; k >= 1; k--) send_nib(4'(k));
        chk("t1_dvalid", data_pvalid_o, 1);
        chk("t1_ivalid", inst_valid_o, 0);
        chk("t1_word", data_pdata_o, 32'h1234_5678);
        data_pready_i = 1'b1;
        tick();
        data_pready_i = 1'b0;
        chk("t1_idle_ready", nib_ready_o, 0);

        // Fetch word with gaps, consumer stalls for five cycles.
        push_tag(1'b1);
        send_word(32'hDEAD_BEEF, 3);
        for (int i = 0; i < 5; i++) begin
            chk("t2_ivalid_held", inst_valid_o, 1);
            chk("t2_word_stable", inst_data_o, 32'hDEAD_BEEF);
            chk("t2_ready_low", nib_ready_o, 0);
            tick();
        end
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk("t2_ivalid_done", inst_valid_o, 0);

        // Fill the FIFO, third push is dropped, words route in tag order.
        inst_ready_i  = 1'b1;
        data_pready_i = 1'b1;
        push_tag(1'b1);
        push_tag(1'b0);
        chk("t3_full", tag_full_o, 1);
        push_tag(1'b1);
        chk("t3_full_after_drop", tag_full_o, 1);
        send_word(32'hA5A5_0F0F, 0);
        chk("t3_first_inst", inst_valid_o, 1);
        chk("t3_first_word", inst_data_o, 32'hA5A5_0F0F);
        tick();
        send_word(32'h0123_4567, 1);
        chk("t3_second_data", data_pvalid_o, 1);
        chk("t3_second_word", data_pdata_o, 32'h0123_4567);
        tick();
        tick();
        chk("t3_idle_ready", nib_ready_o, 0);
        chk("t3_empty_full", tag_full_o, 0);
        inst_ready_i  = 1'b0;
        data_pready_i = 1'b0;

        // Push and pop together while full.
        push_tag(1'b0);
        push_tag(1'b1);
        send_word(32'h1111_2222, 0);
        chk("t4_a_data", data_pvalid_o, 1);
        data_pready_i = 1'b1;
        tag_push_i    = 1'b1;
        tag_is_inst_i = 1'b1;
        tick();
        data_pready_i = 1'b0;
        tag_push_i    = 1'b0;
        chk("t4_full_kept", tag_full_o, 1);
        send_word(32'h3333_4444, 1);
        chk("t4_b_inst", inst_valid_o, 1);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        send_word(32'h5555_6666, 1);
        chk("t4_c_inst", inst_valid_o, 1);
        chk("t4_c_data_low", data_pvalid_o, 0);
        chk("t4_c_word", inst_data_o, 32'h5555_6666);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;

        // Reset in the middle of a word.
        push_tag(1'b0);
        for (int k = 0; k < 4; k++) send_nib(4'(k + 9));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t5_dvalid", data_pvalid_o, 0);
        chk("t5_ready", nib_ready_o, 0);
        chk("t5_full", tag_full_o, 0);
        tick();
        chk("t5_stays_idle", nib_ready_o, 0);
        push_tag(1'b1);
        send_word(32'hCAFE_F00D, 1);
        chk("t5_ivalid", inst_valid_o, 1);
        chk("t5_word", inst_data_o, 32'hCAFE_F00D);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        tick();

        // Unsolicited nibble with no tag outstanding.
        nib_valid_i = 1'b1;
        nib_data_i  = 4'h7;
        tick();
        nib_valid_i = 1'b0;
        chk("t6_err_set", err_o, ERR_EN);
        repeat (3) tick();
        chk("t6_err_held", err_o, ERR_EN);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t6_err_clear", err_o, 0);

        // Randomized traffic: tags, nibble gaps and consumer readiness all vary.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 24;) begin
                    if (!tag_full_o && $urandom_range(0, 2) == 0) begin
                        push_tag(1'($urandom_range(0, 1)));
                        i++;
                    end else begin
                        tick();
                    end
                end
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    w = $urandom();
                    send_word(w, 2);
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    inst_ready_i  = 1'($urandom_range(0, 1));
                    data_pready_i = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        inst_ready_i  = 1'b1;
        data_pready_i = 1'b1;
        repeat (5) tick();
        chk("rand_drained", tq.size(), 0);
        chk("rand_idle", nib_ready_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
